pe_tile_top: RTL and testbench
==============================

Name: pe_tile_top

Overview:
- Single CGRA processing-element tile: 4 sides × 5 tracks of 16-bit input buses, two connection boxes (CB-A, CB-B) selecting ALU operands, a 16-bit ALU with optional operand/result registers, and a switch-box mux driving output track out_BUS16_S3_T1.
- All routing and opcode state lives in memory-mapped config registers, written over a 32-bit address/data config bus gated by tile_id match.
- Instantiated once per array position; the array-level fabric supplies tile_id.

Parameters:
- CFG_AW, 32, config address width
- CFG_DW, 32, config data width
- DW, 16, data path width; fixed by bus port names

Ports:
- clk_in  in  1  sole clock, all state rising-edge
- reset  in  1  asynchronous, active-low reset (reset=0 clears all state)
- tile_id  in  16  tile address, compared with config_addr_in[15:0]
- config_en  in  1  config write strobe, sampled on clk_in rise
- config_addr_in  in  32  [15:0] tile id, [23:16] feature, [31:24] register
- config_data_in  in  32  write data
- in_BUS16_S{s}_T{t}  in  16 each  20 inputs, s=0..3, t=0..4; index i = 5*s + t
- out_BUS16_S3_T1  out  16  switch-box output

Behaviour:
- Config write: on clk_in rise with config_en=1 and config_addr_in[15:0]==tile_id, write the addressed register. Non-matching or unmapped addresses are ignored. New value is effective from the next cycle.
- Register map (feature/reg), unused bits ignored:
  - 0x00/0x00 PE_CTRL: [3:0] op, [4] out_reg_en, [6:5] a_mode, [8:7] b_mode
  - 0x00/0x01 CONST_A [15:0]
  - 0x00/0x02 CONST_B [15:0]
  - 0x01/0x00 CB_A sel [4:0]
  - 0x02/0x00 CB_B sel [4:0]
  - 0x03/0x00 SB sel [4:0]
- Reset: every config register, operand register and result register goes to 0 asynchronously on reset=0. out_BUS16_S3_T1 = 0 while reset is asserted and after release until reconfigured.
- Connection boxes: sel 0..19 selects input index sel; sel 20..31 yields 0.
- Operand mode, independently for a and b:
  - 0: bypass (combinational CB output)
  - 1: registered (one-cycle delay)
  - 2: constant (CONST_A / CONST_B)
  - 3: treated as 0
- ALU: all results are low 16 bits, wrap-around modulo 2^16, no flags.
  - 0 add; 1 sub (a−b); 2 mul (low 16 bits)
  - 3 and; 4 or; 5 xor
  - 6 shl by b[3:0]; 7 lsr by b[3:0]; 8 asr by b[3:0]
  - 9 unsigned min; 10 unsigned max; 11 pass a
  - 12–15 yield 0
- Result: pe_out = ALU result if out_reg_en=0, else ALU result registered one cycle.
- Latency, input to pe_out: 0 cycles with bypass and no out_reg; +1 per enabled register stage.
- Switch box, combinational:
  - sel 0: drives 0
  - sel 1..20: drives input index sel−1
  - sel 21: drives pe_out
  - sel 22..31: drives 0
- Simultaneous config write and data: the current cycle uses the old config.
- Reset asserted mid-operation clears pipeline registers immediately; there is no partial output.

Decomposition:
- Shared package pe_tile_pkg holds:
  - feature IDs: FEAT_PE=0x00, FEAT_CBA=0x01, FEAT_CBB=0x02, FEAT_SB=0x03
  - register offsets
  - opcode enum (OP_ADD … OP_PASSA)
  - operand-mode enum (MODE_BYPASS, MODE_REG, MODE_CONST)
  - SB_SEL_PE=21
- One natural sub-module: pe_alu (pure combinational, a/b/op → result). Muxes, config decode and registers stay in pe_tile_top.

Test Plan:
- Reset: assert reset=0 with all inputs 490 → out_BUS16_S3_T1=0. After release with no config writes → out remains 0.
- Pass-through: SB sel=16 (input index 15 = in_BUS16_S3_T0), in_BUS16_S3_T0=490 → out=490 the same cycle. Change input to 7 → out=7.
- Multiply by two:
  - Config: CB_A sel=10 (S2_T0), b_mode=const, CONST_B=2, op=mul, out_reg_en=1, SB sel=21.
  - Stimulus: all inputs 490.
  - Required: out=980 one cycle after the input is stable.
- Wrap and shift:
  - a=0xFFFF, b=1 const, op=add → out=0x0000.
  - op=shl with b=4, a=490 → out=7840.
  - op=asr with a=0x8000, b=15 → out=0xFFFF.
- Tile-id filter: a config write with config_addr_in[15:0]=0x0016 while tile_id=0x0015 → ignored; out is unchanged.
- Mid-operation reset: with the mul config running, pulse reset=0 → out=0 immediately and all config is cleared. Stays 0 after release.

Source files
------------

// File: rtl/pe_tile_pkg.sv
// Shared constants, config-bus payload layout and encodings for the CGRA PE tile.
package pe_tile_pkg;

  localparam int unsigned CFG_AW = 32;
  localparam int unsigned CFG_DW = 32;
  localparam int unsigned DW     = 16;
  localparam int unsigned NUM_IN = 20;
  localparam int unsigned SEL_W  = 5;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned MODE_W = 2;

  localparam logic [7:0] FEAT_PE  = 8'h00;
  localparam logic [7:0] FEAT_CBA = 8'h01;
  localparam logic [7:0] FEAT_CBB = 8'h02;
  localparam logic [7:0] FEAT_SB  = 8'h03;

  localparam logic [7:0] REG_PE_CTRL = 8'h00;
  localparam logic [7:0] REG_CONST_A = 8'h01;
  localparam logic [7:0] REG_CONST_B = 8'h02;
  localparam logic [7:0] REG_SEL     = 8'h00;

  localparam logic [SEL_W-1:0] SB_SEL_PE = 5'd21;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_MUL   = 4'd2,
    OP_AND   = 4'd3,
    OP_OR    = 4'd4,
    OP_XOR   = 4'd5,
    OP_SHL   = 4'd6,
    OP_LSR   = 4'd7,
    OP_ASR   = 4'd8,
    OP_UMIN  = 4'd9,
    OP_UMAX  = 4'd10,
    OP_PASSA = 4'd11
  } op_e;

  typedef enum logic [MODE_W-1:0] {
    MODE_BYPASS = 2'd0,
    MODE_REG    = 2'd1,
    MODE_CONST  = 2'd2
  } mode_e;

  typedef struct packed {
    logic [7:0]  reg_id;
    logic [7:0]  feat;
    logic [15:0] tile;
  } cfg_addr_t;

endpackage

// File: rtl/pe_tile_top_alu.sv
// Combinational 16-bit PE ALU; every result wraps modulo 2^16.
module pe_alu
  import pe_tile_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  op_e           op,
  output logic [DW-1:0] result_c
);

  always_comb begin
    result_c = '0;
    case (op)
      OP_ADD:   result_c = a + b;
      OP_SUB:   result_c = a - b;
      OP_MUL:   result_c = a * b;
      OP_AND:   result_c = a & b;
      OP_OR:    result_c = a | b;
      OP_XOR:   result_c = a ^ b;
      OP_SHL:   result_c = a << b[3:0];
      OP_LSR:   result_c = a >> b[3:0];
      OP_ASR:   result_c = DW'($signed(a) >>> b[3:0]);
      OP_UMIN:  result_c = (a < b) ? a : b;
      OP_UMAX:  result_c = (a > b) ? a : b;
      OP_PASSA: result_c = a;
      default:  result_c = '0;
    endcase
  end

endmodule

// File: rtl/pe_tile_top.sv
// CGRA PE tile: config registers, connection boxes, operand/result staging and switch box.
module pe_tile_top
  import pe_tile_pkg::*;
(
  input  logic              clk_in,
  input  logic              reset,
  input  logic [15:0]       tile_id,
  input  logic              config_en,
  input  logic [CFG_AW-1:0] config_addr_in,
  input  logic [CFG_DW-1:0] config_data_in,
  input  logic [DW-1:0]     in_BUS16_S0_T0,
  input  logic [DW-1:0]     in_BUS16_S0_T1,
  input  logic [DW-1:0]     in_BUS16_S0_T2,
  input  logic [DW-1:0]     in_BUS16_S0_T3,
  input  logic [DW-1:0]     in_BUS16_S0_T4,
  input  logic [DW-1:0]     in_BUS16_S1_T0,
  input  logic [DW-1:0]     in_BUS16_S1_T1,
  input  logic [DW-1:0]     in_BUS16_S1_T2,
  input  logic [DW-1:0]     in_BUS16_S1_T3,
  input  logic [DW-1:0]     in_BUS16_S1_T4,
  input  logic [DW-1:0]     in_BUS16_S2_T0,
  input  logic [DW-1:0]     in_BUS16_S2_T1,
  input  logic [DW-1:0]     in_BUS16_S2_T2,
  input  logic [DW-1:0]     in_BUS16_S2_T3,
  input  logic [DW-1:0]     in_BUS16_S2_T4,
  input  logic [DW-1:0]     in_BUS16_S3_T0,
  input  logic [DW-1:0]     in_BUS16_S3_T1,
  input  logic [DW-1:0]     in_BUS16_S3_T2,
  input  logic [DW-1:0]     in_BUS16_S3_T3,
  input  logic [DW-1:0]     in_BUS16_S3_T4,
  output logic [DW-1:0]     out_BUS16_S3_T1
);

  logic [DW-1:0]    in_bus [NUM_IN];
  cfg_addr_t        cfg_addr;
  logic             cfg_hit;
  logic             cfg_unused;

  op_e              op_q;
  logic             out_reg_en_q;
  mode_e            a_mode_q, b_mode_q;
  logic [DW-1:0]    const_a_q, const_b_q;
  logic [SEL_W-1:0] cba_sel_q, cbb_sel_q, sb_sel_q;

  logic [DW-1:0]    cb_a, cb_b, op_a, op_b, alu_res, pe_out;
  logic [DW-1:0]    a_q, b_q, res_q;
  logic [SEL_W-1:0] sb_idx;

  assign in_bus = '{in_BUS16_S0_T0, in_BUS16_S0_T1, in_BUS16_S0_T2, in_BUS16_S0_T3, in_BUS16_S0_T4,
                    in_BUS16_S1_T0, in_BUS16_S1_T1, in_BUS16_S1_T2, in_BUS16_S1_T3, in_BUS16_S1_T4,
                    in_BUS16_S2_T0, in_BUS16_S2_T1, in_BUS16_S2_T2, in_BUS16_S2_T3, in_BUS16_S2_T4,
                    in_BUS16_S3_T0, in_BUS16_S3_T1, in_BUS16_S3_T2, in_BUS16_S3_T3, in_BUS16_S3_T4};

  assign cfg_addr   = cfg_addr_t'(config_addr_in);
  assign cfg_hit    = config_en && (cfg_addr.tile == tile_id);
  assign cfg_unused = ^config_data_in[CFG_DW-1:16];

  // Config register file; unmapped feature/register pairs fall through untouched.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      op_q         <= OP_ADD;
      out_reg_en_q <= 1'b0;
      a_mode_q     <= MODE_BYPASS;
      b_mode_q     <= MODE_BYPASS;
      const_a_q    <= '0;
      const_b_q    <= '0;
      cba_sel_q    <= '0;
      cbb_sel_q    <= '0;
      sb_sel_q     <= '0;
    end else if (cfg_hit) begin
      if (cfg_addr.feat == FEAT_PE && cfg_addr.reg_id == REG_PE_CTRL) begin
        op_q         <= op_e'(config_data_in[3:0]);
        out_reg_en_q <= config_data_in[4];
        a_mode_q     <= mode_e'(config_data_in[6:5]);
        b_mode_q     <= mode_e'(config_data_in[8:7]);
      end
      if (cfg_addr.feat == FEAT_PE && cfg_addr.reg_id == REG_CONST_A)
        const_a_q <= config_data_in[DW-1:0];
      if (cfg_addr.feat == FEAT_PE && cfg_addr.reg_id == REG_CONST_B)
        const_b_q <= config_data_in[DW-1:0];
      if (cfg_addr.feat == FEAT_CBA && cfg_addr.reg_id == REG_SEL)
        cba_sel_q <= config_data_in[SEL_W-1:0];
      if (cfg_addr.feat == FEAT_CBB && cfg_addr.reg_id == REG_SEL)
        cbb_sel_q <= config_data_in[SEL_W-1:0];
      if (cfg_addr.feat == FEAT_SB && cfg_addr.reg_id == REG_SEL)
        sb_sel_q <= config_data_in[SEL_W-1:0];
    end
  end

  assign cb_a = (cba_sel_q < SEL_W'(NUM_IN)) ? in_bus[cba_sel_q] : '0;
  assign cb_b = (cbb_sel_q < SEL_W'(NUM_IN)) ? in_bus[cbb_sel_q] : '0;

  always_comb begin
    op_a = '0;
    op_b = '0;
    case (a_mode_q)
      MODE_BYPASS: op_a = cb_a;
      MODE_REG:    op_a = a_q;
      MODE_CONST:  op_a = const_a_q;
      default:     op_a = '0;
    endcase
    case (b_mode_q)
      MODE_BYPASS: op_b = cb_b;
      MODE_REG:    op_b = b_q;
      MODE_CONST:  op_b = const_b_q;
      default:     op_b = '0;
    endcase
  end

  pe_alu u_alu (
    .a        (op_a),
    .b        (op_b),
    .op       (op_q),
    .result_c (alu_res)
  );

  // Operand and result pipeline stages, always loading; the mode muxes decide use.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
    end else begin
      a_q   <= cb_a;
      b_q   <= cb_b;
      res_q <= alu_res;
    end
  end

  assign pe_out = out_reg_en_q ? res_q : alu_res;
  assign sb_idx = sb_sel_q - 5'd1;

  // Switch box: 0 and 22..31 drive zero, 1..20 route an input track, 21 routes the PE.
  always_comb begin
    out_BUS16_S3_T1 = '0;
    if (sb_sel_q == SB_SEL_PE)
      out_BUS16_S3_T1 = pe_out;
    else if (sb_sel_q != '0 && sb_sel_q <= SEL_W'(NUM_IN))
      out_BUS16_S3_T1 = in_bus[sb_idx];
  end

endmodule

// File: tb/tb_pe_tile_top.sv
// Scoreboard bench for pe_tile_top: expectations queued at stimulus, compared when due.
module tb_pe_tile_top;

  logic        clk_in = 1'b0;
  logic        reset;
  logic [15:0] tile_id;
  logic        config_en;
  logic [31:0] config_addr_in;
  logic [31:0] config_data_in;
  logic [15:0] in_v [20];
  logic [15:0] out_BUS16_S3_T1;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [15:0] TID = 16'h0015;

  always #5 clk_in = ~clk_in;

  pe_tile_top dut (
    .clk_in         (clk_in),
    .reset          (reset),
    .tile_id        (tile_id),
    .config_en      (config_en),
    .config_addr_in (config_addr_in),
    .config_data_in (config_data_in),
    .in_BUS16_S0_T0 (in_v[0]),
    .in_BUS16_S0_T1 (in_v[1]),
    .in_BUS16_S0_T2 (in_v[2]),
    .in_BUS16_S0_T3 (in_v[3]),
    .in_BUS16_S0_T4 (in_v[4]),
    .in_BUS16_S1_T0 (in_v[5]),
    .in_BUS16_S1_T1 (in_v[6]),
    .in_BUS16_S1_T2 (in_v[7]),
    .in_BUS16_S1_T3 (in_v[8]),
    .in_BUS16_S1_T4 (in_v[9]),
    .in_BUS16_S2_T0 (in_v[10]),
    .in_BUS16_S2_T1 (in_v[11]),
    .in_BUS16_S2_T2 (in_v[12]),
    .in_BUS16_S2_T3 (in_v[13]),
    .in_BUS16_S2_T4 (in_v[14]),
    .in_BUS16_S3_T0 (in_v[15]),
    .in_BUS16_S3_T1 (in_v[16]),
    .in_BUS16_S3_T2 (in_v[17]),
    .in_BUS16_S3_T3 (in_v[18]),
    .in_BUS16_S3_T4 (in_v[19]),
    .out_BUS16_S3_T1(out_BUS16_S3_T1)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // One config write at tile address tid, launched and retired on falling edges.
  task automatic cfg_wr_t(input logic [15:0] tid, input logic [7:0] feat,
                          input logic [7:0] rg, input logic [31:0] data);
    @(negedge clk_in);
    config_en      = 1'b1;
    config_addr_in = {rg, feat, tid};
    config_data_in = data;
    @(negedge clk_in);
    config_en      = 1'b0;
  endtask

  task automatic cfg_wr(input logic [7:0] feat, input logic [7:0] rg, input logic [31:0] data);
    cfg_wr_t(TID, feat, rg, data);
  endtask

  task automatic set_all(input logic [15:0] v);
    for (int i = 0; i < 20; i++) in_v[i] = v;
  endtask

  // Queue the expectation, let ncyc rising edges pass, then compare the oldest entry.
  task automatic exp_after(input string tag, input logic [15:0] val, input int ncyc);
    exp_t e;
    exp_q.push_back('{tag, val});
    repeat (ncyc) @(posedge clk_in);
    #1;
    e = exp_q.pop_front();
    chk(e.tag, out_BUS16_S3_T1, e.val);
  endtask

  // PE_CTRL word: op, out_reg_en, a_mode, b_mode.
  function automatic logic [31:0] ctrl(input int op, input int oreg, input int am, input int bm);
    return 32'((op & 15) | ((oreg & 1) << 4) | ((am & 3) << 5) | ((bm & 3) << 7));
  endfunction

  localparam logic [7:0] F_PE = 8'h00, F_CBA = 8'h01, F_SB = 8'h03;
  localparam logic [7:0] R_CTRL = 8'h00, R_CA = 8'h01, R_CB = 8'h02, R_SEL = 8'h00;

  initial begin
    reset          = 1'b0;
    tile_id        = TID;
    config_en      = 1'b0;
    config_addr_in = '0;
    config_data_in = '0;
    set_all(16'd490);

    #2 exp_after("reset_out", 16'd0, 0);
    repeat (2) @(negedge clk_in);
    reset = 1'b1;
    exp_after("post_reset", 16'd0, 3);

    // Track pass-through via switch box
    cfg_wr(F_SB, R_SEL, 32'd16);
    exp_after("pass_490", 16'd490, 0);
    @(negedge clk_in);
    in_v[15] = 16'd7;
    exp_after("pass_7", 16'd7, 0);

    // Multiply by two with a registered result
    cfg_wr(F_CBA, R_SEL, 32'd10);
    cfg_wr(F_PE, R_CB, 32'd2);
    cfg_wr(F_PE, R_CTRL, ctrl(2, 1, 0, 2));
    cfg_wr(F_SB, R_SEL, 32'd21);
    set_all(16'd490);
    exp_after("mul_980", 16'd980, 1);
    @(negedge clk_in);
    in_v[10] = 16'd100;
    exp_after("mul_hold", 16'd980, 0);
    exp_after("mul_200", 16'd200, 1);

    // Registered operand plus registered result: two stages
    cfg_wr(F_PE, R_CTRL, ctrl(2, 1, 1, 2));
    @(negedge clk_in);
    in_v[10] = 16'd50;
    exp_after("areg_stage1", 16'd200, 1);
    exp_after("areg_stage2", 16'd100, 1);

    // Combinational ALU checks
    cfg_wr(F_PE, R_CB, 32'd1);
    cfg_wr(F_PE, R_CTRL, ctrl(0, 0, 0, 2));
    in_v[10] = 16'hFFFF;
    exp_after("add_wrap", 16'h0000, 0);
    @(negedge clk_in);
    in_v[10] = 16'd0;
    cfg_wr(F_PE, R_CTRL, ctrl(1, 0, 0, 2));
    exp_after("sub_wrap", 16'hFFFF, 0);
    cfg_wr(F_PE, R_CB, 32'd4);
    cfg_wr(F_PE, R_CTRL, ctrl(6, 0, 0, 2));
    in_v[10] = 16'd490;
    exp_after("shl_4", 16'd7840, 0);
    cfg_wr(F_PE, R_CTRL, ctrl(9, 0, 0, 2));
    exp_after("umin", 16'd4, 0);
    cfg_wr(F_PE, R_CTRL, ctrl(10, 0, 0, 2));
    exp_after("umax", 16'd490, 0);
    cfg_wr(F_PE, R_CB, 32'd15);
    cfg_wr(F_PE, R_CTRL, ctrl(8, 0, 0, 2));
    in_v[10] = 16'h8000;
    exp_after("asr_15", 16'hFFFF, 0);
    cfg_wr(F_PE, R_CTRL, ctrl(7, 0, 0, 2));
    exp_after("lsr_15", 16'h0001, 0);
    cfg_wr(F_PE, R_CTRL, ctrl(12, 0, 0, 2));
    exp_after("op12_zero", 16'h0000, 0);
    cfg_wr(F_PE, R_CA, 32'hABCD_1234);
    cfg_wr(F_PE, R_CTRL, ctrl(11, 0, 2, 0));
    exp_after("const_a", 16'h1234, 0);
    cfg_wr(F_PE, R_CTRL, ctrl(0, 0, 0, 3));
    exp_after("bmode3_zero", 16'h8000, 0);
    cfg_wr(F_CBA, R_SEL, 32'd25);
    cfg_wr(F_PE, R_CTRL, ctrl(11, 0, 0, 0));
    exp_after("cb_sel_oor", 16'h0000, 0);

    // Foreign tile id must not disturb the switch box
    cfg_wr(F_CBA, R_SEL, 32'd10);
    in_v[10] = 16'd321;
    exp_after("pre_filter", 16'd321, 0);
    cfg_wr_t(16'h0016, F_SB, R_SEL, 32'd0);
    exp_after("tile_filter", 16'd321, 1);

    // Mid-operation reset clears pipeline and config
    cfg_wr(F_PE, R_CB, 32'd2);
    cfg_wr(F_PE, R_CTRL, ctrl(2, 1, 0, 2));
    set_all(16'd490);
    exp_after("mul_again", 16'd980, 1);
    @(negedge clk_in);
    reset = 1'b0;
    exp_after("midreset_out", 16'd0, 0);
    @(negedge clk_in);
    reset = 1'b1;
    exp_after("after_midreset", 16'd0, 3);
    cfg_wr(F_SB, R_SEL, 32'd21);
    exp_after("ctrl_cleared", 16'd980, 0);

    if (exp_q.size() != 0) chk("sb_drain", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

endmodule
